// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite palette scheduler.
package sprite_sched_pkg;

  localparam int PAL_INDEX_W = 4;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t TRANSPARENT_RGB_DEFAULT = 12'hE0E;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/sprite_layer_pick.sv
// Opacity / priority test for the layer currently presented to the palette.
// A layer wins only if it is active, nothing higher-priority has won yet,
// and the palette did not return the colour key.
module sprite_layer_pick
  import sprite_sched_pkg::*;
#(
  parameter rgb12_t TRANSPARENT_RGB = TRANSPARENT_RGB_DEFAULT
) (
  input  logic   active_i,
  input  logic   hit_i,
  input  rgb12_t rgb_i,
  output logic   capture_o,
  output logic   hit_o
);

  // Full 12-bit compare: only the exact key is see-through.
  always_comb begin
    capture_o = active_i && !hit_i && (rgb_i != TRANSPARENT_RGB);
    hit_o     = hit_i || capture_o;
  end

endmodule

// File: rtl/sprite_palette_scheduler.sv
// Time-multiplexes one shared 16-entry RGB palette across NUM_LAYERS sprite
// layers; per pixel, keeps the first opaque colour in priority order
// (layer 0 highest) or falls back to the background colour.
// Optional build macro SPRITE_SCHED_EARLY_EXIT_EN: stop scanning on the first
// opaque hit instead of always visiting every layer (colour is unchanged).
module sprite_palette_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int     NUM_LAYERS      = 3,
  parameter rgb12_t TRANSPARENT_RGB = TRANSPARENT_RGB_DEFAULT,
  localparam int    LAYER_W         = $clog2(NUM_LAYERS)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [NUM_LAYERS-1:0]         layer_active,
  input  logic [PAL_INDEX_W*NUM_LAYERS-1:0] layer_index,
  input  logic [11:0]                   bg_rgb,
  output logic                          pal_req,
  output logic [LAYER_W-1:0]            pal_layer,
  output logic [PAL_INDEX_W-1:0]        pal_index,
  input  logic [3:0]                    pal_red,
  input  logic [3:0]                    pal_green,
  input  logic [3:0]                    pal_blue,
  output logic                          out_valid,
  output logic [11:0]                   out_rgb
);

  sched_state_e state_q, state_d;
  logic [LAYER_W-1:0] cnt_q, cnt_d;
  logic               hit_q, hit_d;
  rgb12_t             winner_q, winner_d;
  rgb12_t             out_rgb_q, out_rgb_d;

  logic [NUM_LAYERS-1:0]                 act_q;
  logic [PAL_INDEX_W*NUM_LAYERS-1:0]     idx_q;
  rgb12_t                                bg_q;

  rgb12_t pal_rgb;
  logic   accept;
  logic   last_layer;
  logic   capture;
  logic   hit_next;
  logic   scan_end;

  assign pal_rgb    = {pal_red, pal_green, pal_blue};
  assign pix_ready  = (state_q != SCAN);
  assign accept     = pix_valid && pix_ready;
  assign last_layer = (cnt_q == LAYER_W'(NUM_LAYERS - 1));
  assign out_rgb    = out_rgb_q;

  sprite_layer_pick #(
    .TRANSPARENT_RGB(TRANSPARENT_RGB)
  ) u_pick (
    .active_i (act_q[cnt_q]),
    .hit_i    (hit_q),
    .rgb_i    (pal_rgb),
    .capture_o(capture),
    .hit_o    (hit_next)
  );

`ifdef SPRITE_SCHED_EARLY_EXIT_EN
  assign scan_end = last_layer || capture;
`else
  assign scan_end = last_layer;
`endif

  // Next-state, palette request and output strobe decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    winner_d  = winner_q;
    out_rgb_d = out_rgb_q;
    pal_req   = 1'b0;
    pal_layer = '0;
    pal_index = '0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SCAN;
          cnt_d   = '0;
          hit_d   = 1'b0;
        end
      end

      SCAN: begin
        pal_req   = 1'b1;
        pal_layer = cnt_q;
        pal_index = idx_q[{cnt_q, 2'b00} +: PAL_INDEX_W];
        if (capture) begin
          winner_d = pal_rgb;
        end
        hit_d = hit_next;
        if (scan_end) begin
          state_d   = DONE;
          out_rgb_d = hit_next ? (capture ? pal_rgb : winner_q) : bg_q;
        end else begin
          cnt_d = cnt_q + LAYER_W'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (accept) begin
          state_d = SCAN;
          cnt_d   = '0;
          hit_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, scan bookkeeping and per-pixel input capture.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      winner_q  <= '0;
      out_rgb_q <= '0;
      act_q     <= '0;
      idx_q     <= '0;
      bg_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      winner_q  <= winner_d;
      out_rgb_q <= out_rgb_d;
      if (accept) begin
        act_q <= layer_active;
        idx_q <= layer_index;
        bg_q  <= bg_rgb;
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_scheduler.sv
// Scoreboard bench for sprite_palette_scheduler: a behavioural palette answers
// lookups, every accepted pixel pushes its expected colour and output edge,
// and a negedge monitor pops and compares on each out_valid.
module tb_sprite_palette_scheduler;

  localparam int NL = 3;
  localparam int LW = $clog2(NL);
  localparam logic [11:0] KEY = 12'hE0E;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [NL-1:0]   layer_active = '0;
  logic [4*NL-1:0] layer_index = '0;
  logic [11:0]     bg_rgb = '0;
  logic            pal_req;
  logic [LW-1:0]   pal_layer;
  logic [3:0]      pal_index;
  logic [3:0]      pal_red, pal_green, pal_blue;
  logic            out_valid;
  logic [11:0]     out_rgb;

  logic [11:0] pal_tbl [4][16];

  typedef struct {
    logic [11:0] rgb;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int passed = 0;
  int edge_cnt = 0;
  int last_acc_edge = -1;
  bit mon_en = 1'b0;
  logic [4*NL-1:0] inflight_idx = '0;
  logic [11:0] m_rgb;
  int          m_lat;

  always #5 Clk = ~Clk;

  assign {pal_red, pal_green, pal_blue} = pal_tbl[pal_layer][pal_index];

  sprite_palette_scheduler #(.NUM_LAYERS(NL)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .layer_active(layer_active),
    .layer_index (layer_index),
    .bg_rgb      (bg_rgb),
    .pal_req     (pal_req),
    .pal_layer   (pal_layer),
    .pal_index   (pal_index),
    .pal_red     (pal_red),
    .pal_green   (pal_green),
    .pal_blue    (pal_blue),
    .out_valid   (out_valid),
    .out_rgb     (out_rgb)
  );

  // Reference: first active, non-key layer wins; lat is in clock edges.
  function automatic void model(input logic [NL-1:0] act, input logic [4*NL-1:0] idx,
                                input logic [11:0] bg, output logic [11:0] rgb, output int lat);
    bit found;
    logic [11:0] c;
    found = 1'b0;
    rgb   = bg;
    lat   = NL;
    for (int k = 0; k < NL; k++) begin
      c = pal_tbl[k][idx[4*k +: 4]];
      if (!found && act[k] && c !== KEY) begin
        found = 1'b1;
        rgb   = c;
`ifdef SPRITE_SCHED_EARLY_EXIT_EN
        lat = k + 1;
`endif
      end
    end
  endfunction

  // Accept tracking: push the expected result when the DUT takes a pixel.
  always @(posedge Clk) begin
    edge_cnt <= edge_cnt + 1;
    if (Reset) begin
      sb_q.delete();
    end else if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
      model(layer_active, layer_index, bg_rgb, m_rgb, m_lat);
      sb_q.push_back('{rgb: m_rgb, due: edge_cnt + 1 + m_lat});
      last_acc_edge <= edge_cnt + 1;
      inflight_idx  <= layer_index;
    end
  end

  // Output monitor: compares every out_valid and palette request.
  always @(negedge Clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected_out: out_valid=1 rgb=%h, required no output", out_rgb);
        end else begin
          passed++;
          e = sb_q.pop_front();
          checks++;
          if (out_rgb !== e.rgb)
            $display("FAIL sb_rgb: got %h, required %h", out_rgb, e.rgb);
          else passed++;
          checks++;
          if (edge_cnt !== e.due)
            $display("FAIL sb_latency: output at edge %0d, required edge %0d", edge_cnt, e.due);
          else passed++;
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
        checks++;
        $display("FAIL sb_missed_out: no out_valid by edge %0d (required at %0d)", edge_cnt, sb_q[0].due);
        void'(sb_q.pop_front());
      end

      checks++;
      if (pal_req === 1'b1) begin
        if (pix_ready !== 1'b0 || pal_index !== inflight_idx[pal_layer*4 +: 4])
          $display("FAIL scan_bus: pix_ready=%b pal_index=%h, required 0 and %h",
                   pix_ready, pal_index, inflight_idx[pal_layer*4 +: 4]);
        else passed++;
      end else begin
        if (pal_req !== 1'b0 || pal_layer !== '0 || pal_index !== 4'h0)
          $display("FAIL idle_bus: pal_req=%b pal_layer=%0d pal_index=%h, required 0/0/0",
                   pal_req, pal_layer, pal_index);
        else passed++;
      end
    end
  end

  task automatic send_pixel(input logic [NL-1:0] act, input logic [4*NL-1:0] idx,
                            input logic [11:0] bg);
    bit ok;
    ok = 1'b0;
    @(negedge Clk);
    layer_active = act;
    layer_index  = idx;
    bg_rgb       = bg;
    pix_valid    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pix_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: pix_ready=%b, required 1 within 20 cycles", pix_ready);
    end
    @(negedge Clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [11:0] rgb, output int lat);
    bit ok;
    ok  = 1'b0;
    rgb = 'x;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        ok  = 1'b1;
        rgb = out_rgb;
        lat = edge_cnt - last_acc_edge;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) begin
      checks++;
      $display("FAIL out_timeout: out_valid=%b, required 1 within 20 cycles", out_valid);
    end
    @(negedge Clk);
  endtask

  task automatic wait_drain;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    checks++;
    if (!ok) $display("FAIL drain_timeout: %0d pixels pending, required 0", sb_q.size());
    else passed++;
  endtask

  task automatic clear_palette;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 16; i++)
        pal_tbl[l][i] = 12'h000;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (pix_ready !== 1'b1 || out_valid !== 1'b0 || out_rgb !== 12'h000 || pal_req !== 1'b0)
      $display("FAIL reset_state: ready=%b valid=%b rgb=%h req=%b, required 1/0/000/0",
               pix_ready, out_valid, out_rgb, pal_req);
    else passed++;
    mon_en = 1'b1;
  endtask

  task automatic test_priority;
    logic [11:0] rgb;
    int lat;
    clear_palette();
    pal_tbl[0][5] = 12'h910;
    pal_tbl[1][2] = 12'hFCA;
    send_pixel(3'b011, {4'h0, 4'h2, 4'h5}, 12'h777);
    wait_out(rgb, lat);
    checks++;
    if (rgb !== 12'h910) $display("FAIL priority_rgb: got %h, required 910", rgb);
    else passed++;
    checks++;
`ifdef SPRITE_SCHED_EARLY_EXIT_EN
    if (lat !== 1) $display("FAIL priority_latency: %0d edges, required 1", lat);
`else
    if (lat !== 3) $display("FAIL priority_latency: %0d edges, required 3", lat);
`endif
    else passed++;
    wait_drain();
  endtask

  task automatic test_transparency;
    logic [11:0] rgb;
    int lat;
    clear_palette();
    pal_tbl[0][1] = KEY;
    pal_tbl[1][3] = 12'hF0F;
    pal_tbl[2][4] = 12'h123;
    send_pixel(3'b111, {4'h4, 4'h3, 4'h1}, 12'h555);
    wait_out(rgb, lat);
    checks++;
    if (rgb !== 12'hF0F) $display("FAIL transparency_rgb: got %h, required F0F", rgb);
    else passed++;
    wait_drain();
  endtask

  task automatic test_background;
    int n_req;
    int n_out;
    clear_palette();
    n_req = 0;
    n_out = 0;
    send_pixel(3'b000, {4'h1, 4'h2, 4'h3}, 12'h246);
    for (int i = 0; i < 8; i++) begin
      if (pal_req === 1'b1) n_req++;
      if (out_valid === 1'b1) begin
        n_out++;
        checks++;
        if (out_rgb !== 12'h246) $display("FAIL background_rgb: got %h, required 246", out_rgb);
        else passed++;
      end
      @(negedge Clk);
    end
    checks++;
    if (n_req !== NL) $display("FAIL background_pal_req: %0d cycles, required %0d", n_req, NL);
    else passed++;
    checks++;
    if (n_out !== 1) $display("FAIL background_out_count: %0d strobes, required 1", n_out);
    else passed++;
    checks++;
    if (out_rgb !== 12'h246) $display("FAIL background_hold: got %h, required 246", out_rgb);
    else passed++;
    wait_drain();
  endtask

  task automatic test_back_to_back;
    int last_out;
    int n_out;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 16; i++)
        pal_tbl[l][i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom());
    last_out = -1;
    n_out = 0;
    @(negedge Clk);
    pix_valid = 1'b1;
    for (int c = 0; c < 26; c++) begin
      layer_active = NL'($urandom());
      layer_index  = (4*NL)'($urandom());
      bg_rgb       = 12'($urandom());
      @(negedge Clk);
      if (out_valid === 1'b1) begin
        n_out++;
`ifndef SPRITE_SCHED_EARLY_EXIT_EN
        if (last_out >= 0) begin
          checks++;
          if (edge_cnt - last_out !== NL + 1)
            $display("FAIL b2b_interval: %0d edges, required %0d", edge_cnt - last_out, NL + 1);
          else passed++;
        end
`endif
        last_out = edge_cnt;
      end
    end
    pix_valid = 1'b0;
    checks++;
    if (n_out < 5) $display("FAIL b2b_count: %0d outputs, required at least 5", n_out);
    else passed++;
    wait_drain();
  endtask

  task automatic test_midscan_reset;
    int n_out;
    clear_palette();
    n_out = 0;
    send_pixel(3'b000, {4'h0, 4'h0, 4'h0}, 12'h9AB);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (pix_ready !== 1'b1 || pal_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL midscan_reset_state: ready=%b req=%b valid=%b, required 1/0/0",
               pix_ready, pal_req, out_valid);
    else passed++;
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) n_out++;
      @(negedge Clk);
    end
    checks++;
    if (n_out !== 0) $display("FAIL midscan_dropped: %0d strobes, required 0", n_out);
    else passed++;
    checks++;
    if (pix_ready !== 1'b1) $display("FAIL midscan_idle: pix_ready=%b, required 1", pix_ready);
    else passed++;
  endtask

`ifdef SPRITE_SCHED_EARLY_EXIT_EN
  task automatic test_early_exit;
    logic [11:0] rgb;
    int lat;
    clear_palette();
    pal_tbl[0][7] = 12'h0A5;
    send_pixel(3'b111, {4'h1, 4'h1, 4'h7}, 12'h111);
    wait_out(rgb, lat);
    checks++;
    if (rgb !== 12'h0A5 || lat !== 1)
      $display("FAIL early_exit: rgb=%h lat=%0d, required 0A5 and 1", rgb, lat);
    else passed++;
    wait_drain();
  endtask
`endif

  initial begin
    clear_palette();
    test_reset();
    test_priority();
    test_transparency();
    test_background();
    test_back_to_back();
    test_midscan_reset();
`ifdef SPRITE_SCHED_EARLY_EXIT_EN
    test_early_exit();
`endif
    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required completion");
    $fatal(1, "timeout");
  end

endmodule
